vc_output_scheduler: RTL and testbench

- Per-output-port scheduler for the 5-port mesh router. One instance sits behind each output link (E, W, N, S, PE).
- It shares the output between NUM_REQ input interfaces on two virtual channels: VC0 (even) and VC1 (odd).
- Each VC has its own round-robin arbiter and FIFO. The link is drained one VC per cycle, selected by the router polarity, under a send/ready handshake.
- It replaces the arbiter + output-control pair with a buffered, VC-aware version.

---
 rtl/vc_output_scheduler.sv | 162 ++++++++++++++++
 tb/tb_vc_output_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vc_output_scheduler.sv
// Buffered two-VC output scheduler for one router output link.
// Per-VC round-robin arbiter feeds a small FIFO; link drains VC == polarity.
module vc_output_scheduler #(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_REQ      = 4,
  parameter int BUFFER_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         polarity,
  input  logic [NUM_REQ-1:0]           req_vc0,
  input  logic [NUM_REQ-1:0]           req_vc1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_vc0,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_vc1,
  output logic [NUM_REQ-1:0]           grant_vc0,
  output logic [NUM_REQ-1:0]           grant_vc1,
  output logic                         so,
  input  logic                         ro,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         vc_out,
  output logic                         full_vc0,
  output logic                         full_vc1,
  output logic                         empty_vc0,
  output logic                         empty_vc1
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CW = $clog2(BUFFER_DEPTH + 1);

  logic [1:0][NUM_REQ-1:0]            req_w;
  logic [1:0][NUM_REQ*DATA_WIDTH-1:0] din_w;
  logic [1:0][NUM_REQ-1:0]            gnt_w;
  logic [1:0][DATA_WIDTH-1:0]         head_w;
  logic [1:0]                         deq_w;
  logic [1:0]                         full_w;
  logic [1:0]                         empty_w;

  assign req_w[0] = req_vc0;
  assign req_w[1] = req_vc1;
  assign din_w[0] = data_vc0;
  assign din_w[1] = data_vc1;

  assign grant_vc0 = gnt_w[0];
  assign grant_vc1 = gnt_w[1];
  assign full_vc0  = full_w[0];
  assign full_vc1  = full_w[1];
  assign empty_vc0 = empty_w[0];
  assign empty_vc1 = empty_w[1];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(BUFFER_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  for (genvar v = 0; v < 2; v++) begin : g_vc
    logic [PW-1:0]         rr_q, rr_d;
    logic [AW-1:0]         wp_q, wp_d;
    logic [AW-1:0]         rp_q, rp_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUFFER_DEPTH];
    logic [NUM_REQ-1:0]    gnt;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  is_full, is_empty, enq, deq;

    assign is_full  = (cnt_q == CW'(BUFFER_DEPTH));
    assign is_empty = (cnt_q == '0);
    assign enq      = |gnt;
    assign deq      = (polarity == (v == 1)) && !is_empty && ro;

    assign gnt_w[v]   = gnt;
    assign head_w[v]  = mem_q[rp_q];
    assign deq_w[v]   = deq;
    assign full_w[v]  = is_full;
    assign empty_w[v] = is_empty;

    // Round-robin pick starting after last winner; blocked while full or in reset
    always_comb begin
      logic [PW-1:0] idx;
      idx   = '0;
      gnt   = '0;
      rr_d  = rr_q;
      wdata = '0;
      if (reset && !is_full) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          idx = PW'((int'(rr_q) + 1 + i) % NUM_REQ);
          if (gnt == '0 && req_w[v][idx]) begin
            gnt[idx] = 1'b1;
            rr_d     = idx;
          end
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) wdata = din_w[v][i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    // FIFO pointer, occupancy and storage next-state
    always_comb begin
      wp_d  = enq ? nxt(wp_q) : wp_q;
      rp_d  = deq ? nxt(rp_q) : rp_q;
      cnt_d = cnt_q;
      if (enq && !deq) cnt_d = cnt_q + CW'(1);
      else if (deq && !enq) cnt_d = cnt_q - CW'(1);
      mem_d = mem_q;
      if (enq) mem_d[wp_q] = wdata;
    end

    // Per-VC arbiter and FIFO state
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rr_q  <= PW'(NUM_REQ - 1);
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
        for (int i = 0; i < BUFFER_DEPTH; i++) mem_q[i] <= '0;
      end else begin
        rr_q  <= rr_d;
        wp_q  <= wp_d;
        rp_q  <= rp_d;
        cnt_q <= cnt_d;
        mem_q <= mem_d;
      end
    end
  end

  logic                  so_q, so_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  vc_q, vc_d;

  // Link register: load head of the VC allowed by polarity
  always_comb begin
    so_d   = deq_w[0] | deq_w[1];
    data_d = data_q;
    vc_d   = vc_q;
    if (deq_w[1]) begin
      data_d = head_w[1];
      vc_d   = 1'b1;
    end else if (deq_w[0]) begin
      data_d = head_w[0];
      vc_d   = 1'b0;
    end
  end

  // Registered link outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      so_q   <= 1'b0;
      data_q <= '0;
      vc_q   <= 1'b0;
    end else begin
      so_q   <= so_d;
      data_q <= data_d;
      vc_q   <= vc_d;
    end
  end

  assign so       = so_q;
  assign data_out = data_q;
  assign vc_out   = vc_q;

endmodule

// File: tb/tb_vc_output_scheduler.sv
// Directed table bench for vc_output_scheduler.
// Rows: inputs for one cycle, expected grants before the edge and outputs after.
module tb_vc_output_scheduler;
  localparam int DW = 64;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            polarity;
  logic [NR-1:0]   req_vc0, req_vc1;
  logic [NR*DW-1:0] data_vc0, data_vc1;
  logic [NR-1:0]   grant_vc0, grant_vc1;
  logic            so, ro, vc_out;
  logic [DW-1:0]   data_out;
  logic            full_vc0, full_vc1, empty_vc0, empty_vc1;

  int total = 0;
  int bad   = 0;

  vc_output_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BUFFER_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .req_vc0(req_vc0), .req_vc1(req_vc1),
    .data_vc0(data_vc0), .data_vc1(data_vc1),
    .grant_vc0(grant_vc0), .grant_vc1(grant_vc1),
    .so(so), .ro(ro), .data_out(data_out), .vc_out(vc_out),
    .full_vc0(full_vc0), .full_vc1(full_vc1),
    .empty_vc0(empty_vc0), .empty_vc1(empty_vc1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pol;
    logic          ro;
    logic [3:0]    r0;
    logic [3:0]    r1;
    logic [63:0]   base;
    logic [3:0]    g0;
    logic [3:0]    g1;
    logic          so;
    logic [63:0]   dout;
    logic          vc;
    logic          f0;
    logic          f1;
    logic          e0;
    logic          e1;
  } vec_t;

  function automatic logic [NR*DW-1:0] mk(input logic [63:0] base);
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = base + 64'(i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // A full VC must never grant
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      if ((full_vc0 && |grant_vc0) || (full_vc1 && |grant_vc1)) begin
        bad++;
        $display("FAIL full_grant got=%b/%b want=0", grant_vc0, grant_vc1);
      end
    end
  end

  task automatic run(input vec_t v, input int n);
    @(negedge clk);
    polarity = v.pol;
    ro       = v.ro;
    req_vc0  = v.r0;
    req_vc1  = v.r1;
    data_vc0 = mk(v.base);
    data_vc1 = mk(v.base);
    #1;
    chk($sformatf("r%0d_g0", n), 64'(grant_vc0), 64'(v.g0));
    chk($sformatf("r%0d_g1", n), 64'(grant_vc1), 64'(v.g1));
    @(posedge clk);
    #1;
    chk($sformatf("r%0d_so", n), 64'(so), 64'(v.so));
    chk($sformatf("r%0d_dout", n), data_out, v.dout);
    chk($sformatf("r%0d_vc", n), 64'(vc_out), 64'(v.vc));
    chk($sformatf("r%0d_f0", n), 64'(full_vc0), 64'(v.f0));
    chk($sformatf("r%0d_f1", n), 64'(full_vc1), 64'(v.f1));
    chk($sformatf("r%0d_e0", n), 64'(empty_vc0), 64'(v.e0));
    chk($sformatf("r%0d_e1", n), 64'(empty_vc1), 64'(v.e1));
  endtask

  vec_t tbl [$];

  initial begin
    //        pol ro  r0    r1    base     g0    g1    so  dout     vc f0 f1 e0 e1
    // round robin on VC0, drain only on polarity 0
    tbl.push_back('{0,1,4'hF,4'h0,64'h10, 4'h1,4'h0, 0,64'h0, 0,0,0,0,1});
    tbl.push_back('{1,1,4'hF,4'h0,64'h10, 4'h2,4'h0, 0,64'h0, 0,1,0,0,1});
    tbl.push_back('{0,1,4'hF,4'h0,64'h10, 4'h0,4'h0, 1,64'h10,0,0,0,0,1});
    tbl.push_back('{1,1,4'hF,4'h0,64'h10, 4'h4,4'h0, 0,64'h10,0,1,0,0,1});
    tbl.push_back('{0,1,4'hF,4'h0,64'h10, 4'h0,4'h0, 1,64'h11,0,0,0,0,1});
    tbl.push_back('{1,1,4'hF,4'h0,64'h10, 4'h8,4'h0, 0,64'h11,0,1,0,0,1});
    tbl.push_back('{0,1,4'hF,4'h0,64'h10, 4'h0,4'h0, 1,64'h12,0,0,0,0,1});
    tbl.push_back('{1,1,4'hF,4'h0,64'h10, 4'h1,4'h0, 0,64'h12,0,1,0,0,1});
    tbl.push_back('{0,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 1,64'h13,0,0,0,0,1});
    tbl.push_back('{1,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 0,64'h13,0,0,0,0,1});
    tbl.push_back('{0,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 1,64'h10,0,0,0,1,1});
    tbl.push_back('{1,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 0,64'h10,0,0,0,1,1});
    // backpressure on VC1, fill to full, then drain
    tbl.push_back('{1,0,4'h0,4'h1,64'hA1, 4'h0,4'h1, 0,64'h10,0,0,0,1,0});
    tbl.push_back('{0,0,4'h0,4'h1,64'hA2, 4'h0,4'h1, 0,64'h10,0,0,1,1,0});
    tbl.push_back('{1,0,4'h0,4'h1,64'hA3, 4'h0,4'h0, 0,64'h10,0,0,1,1,0});
    tbl.push_back('{0,1,4'h0,4'h1,64'hA3, 4'h0,4'h0, 0,64'h10,0,0,1,1,0});
    tbl.push_back('{1,1,4'h0,4'h1,64'hA3, 4'h0,4'h0, 1,64'hA1,1,0,0,1,0});
    tbl.push_back('{0,1,4'h0,4'h1,64'hA3, 4'h0,4'h1, 0,64'hA1,1,0,1,1,0});
    tbl.push_back('{1,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 1,64'hA2,1,0,0,1,0});
    tbl.push_back('{0,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 0,64'hA2,1,0,0,1,0});
    tbl.push_back('{1,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 1,64'hA3,1,0,0,1,1});
    // VC0 full with pop: no grant in pop cycle, grant next cycle
    tbl.push_back('{1,1,4'h2,4'h0,64'h20, 4'h2,4'h0, 0,64'hA3,1,0,0,0,1});
    tbl.push_back('{1,1,4'h2,4'h0,64'h30, 4'h2,4'h0, 0,64'hA3,1,1,0,0,1});
    tbl.push_back('{0,1,4'h2,4'h0,64'h30, 4'h0,4'h0, 1,64'h21,0,0,0,0,1});
    tbl.push_back('{1,1,4'h2,4'h0,64'h40, 4'h2,4'h0, 0,64'h21,0,1,0,0,1});
    tbl.push_back('{0,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 1,64'h31,0,0,0,0,1});
    tbl.push_back('{1,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 0,64'h31,0,0,0,0,1});
    tbl.push_back('{0,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 1,64'h41,0,0,0,1,1});
    tbl.push_back('{1,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 0,64'h41,0,0,0,1,1});
    // polarity gating: one VC0 flit waits out a polarity-1 cycle
    tbl.push_back('{0,1,4'h1,4'h0,64'h55, 4'h1,4'h0, 0,64'h41,0,0,0,0,1});
    tbl.push_back('{1,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 0,64'h41,0,0,0,0,1});
    tbl.push_back('{0,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 1,64'h55,0,0,0,1,1});
    tbl.push_back('{1,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 0,64'h55,0,0,0,1,1});
    // both VCs granted together, link alternates
    tbl.push_back('{0,1,4'h4,4'h8,64'h60, 4'h4,4'h8, 0,64'h55,0,0,0,0,0});
    tbl.push_back('{1,1,4'h4,4'h8,64'h70, 4'h4,4'h8, 1,64'h63,1,1,0,0,0});
    tbl.push_back('{0,1,4'h4,4'h8,64'h80, 4'h0,4'h8, 1,64'h62,0,0,1,0,0});
    tbl.push_back('{1,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 1,64'h73,1,0,0,0,0});
    tbl.push_back('{0,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 1,64'h72,0,0,0,1,0});
    tbl.push_back('{1,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 1,64'h83,1,0,0,1,1});
    tbl.push_back('{0,1,4'h0,4'h0,64'h0,  4'h0,4'h0, 0,64'h83,1,0,0,1,1});

    // reset held with requests present
    reset    = 1'b0;
    polarity = 1'b0;
    ro       = 1'b1;
    req_vc0  = 4'hF;
    req_vc1  = 4'h0;
    data_vc0 = mk(64'hE0);
    data_vc1 = mk(64'hE0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_g0", 64'(grant_vc0), 64'h0);
    chk("rst_so", 64'(so), 64'h0);
    chk("rst_dout", data_out, 64'h0);
    chk("rst_e0", 64'(empty_vc0), 64'h1);
    chk("rst_f0", 64'(full_vc0), 64'h0);

    @(negedge clk);
    reset   = 1'b1;
    req_vc0 = 4'h0;

    // load both VCs, then reset mid-stream
    @(negedge clk);
    polarity = 1'b0;
    ro       = 1'b0;
    req_vc0  = 4'h1;
    req_vc1  = 4'h1;
    @(negedge clk);
    polarity = 1'b1;
    ro       = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_so", 64'(so), 64'h1);
    chk("mid_dout", data_out, 64'hE0);
    chk("mid_vc", 64'(vc_out), 64'h1);
    chk("mid_f0", 64'(full_vc0), 64'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_g0", 64'(grant_vc0), 64'h0);
    chk("arst_g1", 64'(grant_vc1), 64'h0);
    chk("arst_so", 64'(so), 64'h0);
    chk("arst_dout", data_out, 64'h0);
    chk("arst_vc", 64'(vc_out), 64'h0);
    chk("arst_f0", 64'(full_vc0), 64'h0);
    chk("arst_e0", 64'(empty_vc0), 64'h1);
    chk("arst_e1", 64'(empty_vc1), 64'h1);
    @(negedge clk);
    req_vc0 = 4'h0;
    req_vc1 = 4'h0;
    reset   = 1'b1;

    foreach (tbl[i]) run(tbl[i], i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
